sd_spi_byte_engine: RTL
=======================

// Module: sd_spi_byte_engine
// PURPOSE
//  SPI-mode master that drives the SD card pins from on-chip logic instead of the FTDI passthrough.
//  Sits directly downstream of the byte source (host command logic) and directly upstream of the SD card socket.
//  Exchanges one byte per transfer, full duplex, with a valid/ready handshake toward the byte source.
//  Generates the SD power-up dummy clock burst.
// PARAMETERS
//  DIV_SLOW     30  clk cycles per SCLK half-period in slow mode (12 MHz -> 200 kHz); also used for init
//  DIV_FAST     3   clk cycles per SCLK half-period in fast mode (12 MHz -> 2 MHz); must be >= 1
//  INIT_CLOCKS  80  full SCLK periods emitted by the init burst; must be >= 74
// PORTS
//  clk         in   1  system clock
//  rst         in   1  synchronous reset, active-high
//  tx_data     in   8  byte to send, MSB first
//  tx_valid    in   1  tx_data valid
//  tx_ready    out  1  engine can accept a byte this cycle
//  rx_data     out  8  byte received during the last transfer
//  rx_valid    out  1  one-cycle pulse: rx_data updated
//  fast_mode   in   1  1 = DIV_FAST, 0 = DIV_SLOW; sampled at byte acceptance
//  cs_assert   in   1  1 = drive card CS active (low)
//  init_start  in   1  pulse: run the init clock burst
//  busy        out  1  state != IDLE
//  sd_sclk     out  1  SD SPI clock (mode 0, idle low)
//  sd_mosi     out  1  SD DI
//  sd_miso     in   1  SD DO
//  sd_cs_n     out  1  SD chip select, active low
// BEHAVIOUR
//  - Reset values: sd_sclk=0, sd_mosi=1, sd_cs_n=1, rx_data=0, rx_valid=0, busy=0.
//    tx_ready=1 from the first cycle after reset is released. FSM goes to IDLE.
//  - FSM states are IDLE, INIT and SHIFT.
//    - IDLE -> INIT when init_start=1.
//    - IDLE -> SHIFT when tx_valid && tx_ready.
//    - INIT -> IDLE after INIT_CLOCKS periods.
//    - SHIFT -> IDLE after 16 SCLK edges.
//  - tx_ready = (state==IDLE) && !init_start. If init_start and tx_valid are high in the same cycle, init wins and no byte is accepted.
//  - init_start outside IDLE is ignored. tx_valid outside IDLE is not accepted; the source holds it.
//  - Divider
//    - A half-period counter loads DIV-1 on entry to SHIFT/INIT and counts down.
//    - Each time it reaches 0 it reloads and produces one SCLK edge (sd_sclk toggles).
//    - DIV is latched at acceptance; fast_mode changes mid-byte have no effect. INIT always uses DIV_SLOW.
//  - SHIFT, SPI mode 0
//    - sd_mosi = tx_data[7] from the cycle after acceptance.
//    - On each rising edge, sd_miso is sampled into the shift register LSB.
//    - On each falling edge except the 16th, the next bit is shifted out on sd_mosi.
//    - After the 16th edge (falling, sd_sclk=0):
//      - rx_data <= shifted byte.
//      - rx_valid=1 for exactly one cycle.
//      - state=IDLE and tx_ready=1 in that same cycle.
//    - Latency: rx_valid occurs exactly 16*DIV+1 cycles after the acceptance cycle.
//    - Back-to-back: if tx_valid stays high, the next byte is accepted in the rx_valid cycle. No extra idle cycles.
//  - sd_mosi returns to 1 in IDLE.
//  - INIT: sd_cs_n forced 1 and sd_mosi=1 while INIT_CLOCKS SCLK periods run (2*INIT_CLOCKS edges). Then IDLE; rx_valid is not pulsed.
//  - CS
//    - In IDLE: sd_cs_n <= !cs_assert (registered, 1 cycle latency).
//    - In SHIFT: sd_cs_n is frozen; cs_assert changes take effect on return to IDLE.
//    - In INIT: sd_cs_n is forced 1.
//  - rst mid-transfer aborts it: every output takes its reset value on the next cycle, with no rx_valid.
// TESTING
//  1. Reset, then init_start pulse:
//     - exactly 80 sd_sclk rising edges, each half-period 30 clk;
//     - sd_cs_n=1 and sd_mosi=1 throughout;
//     - busy drops afterwards with no rx_valid.
//  2. cs_assert=1, fast_mode=1, send 0xA5 with sd_miso driven by a 0x3C slave model:
//     - MOSI shows A5 MSB first, stable at each rising edge;
//     - rx_data=0x3C;
//     - rx_valid pulses 49 cycles after acceptance.
//  3. tx_valid held high with bytes 0x40,0x00,0x00,0x00,0x00,0x95 (CMD0):
//     - 6 transfers back-to-back with no gap cycles;
//     - sd_cs_n stays 0 throughout.
//  4. init_start and tx_valid high in the same IDLE cycle:
//     - tx_ready=0 and INIT runs;
//     - the byte is accepted on the first cycle back in IDLE.
//  5. Toggle fast_mode and cs_assert mid-byte:
//     - the byte keeps the latched divider;
//     - sd_cs_n changes only after rx_valid.
//  6. Assert rst during edge 7 of a transfer:
//     - next cycle sd_sclk=0, sd_cs_n=1, sd_mosi=1, busy=0, tx_ready=1 after release;
//     - no rx_valid.

Source files
------------

// File: rtl/sd_spi_byte_engine.sv
// sd_spi_byte_engine: SPI-mode 0 master for the SD card socket.
// Moves one byte per transfer, full duplex, MSB first. Also produces the
// power-up dummy clock burst, which runs with CS released and MOSI high.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | SCLK low, MOSI high, CS follows cs_assert, ready for a byte
// INIT  | power-up burst: 2*INIT_CLOCKS SCLK edges, CS forced high
// SHIFT | one byte exchange: 16 SCLK edges at the latched divider
module sd_spi_byte_engine #(
    parameter int DIV_SLOW    = 30,
    parameter int DIV_FAST    = 3,
    parameter int INIT_CLOCKS = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       fast_mode,
    input  logic       cs_assert,
    input  logic       init_start,
    output logic       busy,
    output logic       sd_sclk,
    output logic       sd_mosi,
    input  logic       sd_miso,
    output logic       sd_cs_n
);

    localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int CW      = $clog2(DIV_MAX + 1);
    localparam int EW      = $clog2(2 * INIT_CLOCKS);

    localparam logic [CW-1:0] SLOW_RELOAD = CW'(DIV_SLOW - 1);
    localparam logic [CW-1:0] FAST_RELOAD = CW'(DIV_FAST - 1);
    localparam logic [EW-1:0] INIT_LAST   = EW'(2 * INIT_CLOCKS - 1);
    localparam logic [EW-1:0] SHIFT_LAST  = EW'(15);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        SHIFT
    } state_t;

    state_t        state;
    logic [CW-1:0] half_cnt;
    logic [CW-1:0] reload;
    logic [EW-1:0] edge_cnt;
    logic [7:0]    tx_shift;
    logic [7:0]    rx_shift;
    logic          half_done;

    assign half_done = (half_cnt == '0);
    // Init request has priority over a pending byte in the same cycle.
    assign tx_ready  = (state == IDLE) && !init_start && !rst;
    assign busy      = (state != IDLE);

    // Sequencer: divider, SCLK edge generation, shift registers and pin drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            half_cnt <= '0;
            reload   <= '0;
            edge_cnt <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            sd_sclk  <= 1'b0;
            sd_mosi  <= 1'b1;
            sd_cs_n  <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    sd_sclk  <= 1'b0;
                    sd_mosi  <= 1'b1;
                    edge_cnt <= '0;
                    if (init_start) begin
                        state    <= INIT;
                        reload   <= SLOW_RELOAD;
                        half_cnt <= SLOW_RELOAD;
                        sd_cs_n  <= 1'b1;
                    end else begin
                        sd_cs_n <= !cs_assert;
                        if (tx_valid) begin
                            // Divider is frozen for the whole byte.
                            state    <= SHIFT;
                            reload   <= fast_mode ? FAST_RELOAD : SLOW_RELOAD;
                            half_cnt <= fast_mode ? FAST_RELOAD : SLOW_RELOAD;
                            tx_shift <= tx_data;
                            sd_mosi  <= tx_data[7];
                        end
                    end
                end
                INIT: begin
                    sd_cs_n <= 1'b1;
                    sd_mosi <= 1'b1;
                    if (half_done) begin
                        half_cnt <= reload;
                        sd_sclk  <= !sd_sclk;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (edge_cnt == INIT_LAST) begin
                            state <= IDLE;
                        end
                    end else begin
                        half_cnt <= half_cnt - 1'b1;
                    end
                end
                SHIFT: begin
                    if (half_done) begin
                        half_cnt <= reload;
                        sd_sclk  <= !sd_sclk;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (!edge_cnt[0]) begin
                            // Rising edge: capture card data.
                            rx_shift <= {rx_shift[6:0], sd_miso};
                        end else if (edge_cnt == SHIFT_LAST) begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                            sd_mosi  <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            // Falling edge: present next bit.
                            sd_mosi  <= tx_shift[6];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end else begin
                        half_cnt <= half_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
